// File: rtl/uart_dbg_master_pkg.sv
// Shared constants and types for the UART debug bus master.
// Holds the default command/response bytes and serial timing, the frame FSM
// and RX state encodings, and a small helper for loading down-counting timers.
package uart_dbg_master_pkg;

  localparam logic [7:0] CMD_WR_DEF   = 8'hA5;
  localparam logic [7:0] CMD_RD_DEF   = 8'h5A;
  localparam logic [7:0] ACK_BYTE_DEF = 8'hAC;
  localparam int         CLK_DIV_DEF  = 434;    // 50 MHz / 115200 baud
  localparam int         TIMEOUT_DEF  = 65535;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS_WR,
    S_BUS_RD,
    S_RD_CAP,
    S_RESP
  } frame_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Down-counters run load..0, so a period of N cycles loads N-1.
  function automatic logic [15:0] tmr_load(input int cycles);
    return 16'(cycles - 1);
  endfunction

endpackage

// File: rtl/uart_dbg_txser.sv
// Byte serialiser for the debug master's response line (8N1).
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   start_i   - one-cycle request to send byte_i (accepted only when idle)
//   byte_i    - byte to send, sampled together with start_i
//   tx_pin    - serial output, idle high
//   done_o    - one-cycle pulse in the cycle after the stop bit ends
module uart_dbg_txser
  import uart_dbg_master_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       tx_pin,
  output logic       done_o
);

  logic [8:0]  shift_q;   // data bits then the stop bit; start bit is driven directly
  logic [15:0] tmr_q;
  logic [3:0]  bit_q;     // 0 = start bit, 1..8 = data, 9 = stop
  logic        active_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_pin   <= 1'b1;
      done_o   <= 1'b0;
      active_q <= 1'b0;
      tmr_q    <= '0;
      bit_q    <= '0;
    end else begin
      done_o <= 1'b0;
      if (!active_q) begin
        if (start_i) begin
          tx_pin   <= 1'b0;
          shift_q  <= {1'b1, byte_i};
          tmr_q    <= tmr_load(CLK_DIV);
          bit_q    <= '0;
          active_q <= 1'b1;
        end
      end else if (tmr_q != 16'd0) begin
        tmr_q <= tmr_q - 16'd1;
      end else if (bit_q == 4'd9) begin
        active_q <= 1'b0;
        done_o   <= 1'b1;
      end else begin
        // Shift in ones so the line stays high once the stop bit is out.
        tx_pin  <= shift_q[0];
        shift_q <= {1'b1, shift_q[8:1]};
        bit_q   <= bit_q + 4'd1;
        tmr_q   <= tmr_load(CLK_DIV);
      end
    end
  end

endmodule

// File: rtl/uart_dbg_master.sv
// UART-driven 32-bit bus initiator for host debug and program download.
// Frames (multi-byte fields LSB first):
//   write: CMD_WR addr[4] data[4]  -> one we_o strobe, reply ACK_BYTE
//   read : CMD_RD addr[4]          -> one rd_o strobe, reply data[4]
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   rx_pin    - serial in from host (asynchronous, idle high)
//   tx_pin    - serial out to host (idle high)
//   waddr_o, data_o, sel_o, we_o - bus write address/data/byte enables/strobe
//   raddr_o, rd_o, data_i        - bus read address/strobe, data the cycle after rd_o
//   busy_o    - high whenever a frame is in progress
module uart_dbg_master
  import uart_dbg_master_pkg::*;
#(
  parameter int         CLK_DIV  = CLK_DIV_DEF,
  parameter int         TIMEOUT  = TIMEOUT_DEF,
  parameter logic [7:0] CMD_WR   = CMD_WR_DEF,
  parameter logic [7:0] CMD_RD   = CMD_RD_DEF,
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_pin,
  output logic        tx_pin,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic [31:0] raddr_o,
  output logic        rd_o,
  input  logic [31:0] data_i,
  output logic        busy_o
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  // ---------------- RX deserialiser ----------------
  logic        rx_s1, rx_s2, rx_d;
  rx_state_t   rx_st;
  logic [15:0] rx_tmr;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_d   <= 1'b1;
      rx_st  <= RX_IDLE;
      rx_tmr <= '0;
      rx_bit <= '0;
      rx_vld <= 1'b0;
    end else begin
      rx_s1  <= rx_pin;
      rx_s2  <= rx_s1;
      rx_d   <= rx_s2;
      rx_vld <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          if (rx_d && !rx_s2) begin
            rx_tmr <= tmr_load(CLK_DIV / 2);
            rx_st  <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tmr != 16'd0) begin
            rx_tmr <= rx_tmr - 16'd1;
          end else if (rx_s2) begin
            rx_st <= RX_IDLE;   // line back high at mid start bit: glitch
          end else begin
            rx_tmr <= tmr_load(CLK_DIV);
            rx_bit <= '0;
            rx_st  <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_tmr != 16'd0) begin
            rx_tmr <= rx_tmr - 16'd1;
          end else begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_tmr <= tmr_load(CLK_DIV);
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_tmr != 16'd0) begin
            rx_tmr <= rx_tmr - 16'd1;
          end else begin
            // A low stop bit is a framing error: the byte is simply not delivered.
            rx_vld <= rx_s2;
            rx_st  <= RX_IDLE;
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------- TX serialiser ----------------
  logic       tx_start;
  logic       tx_done;
  logic [31:0] resp_q;   // response bytes, next one to send in [7:0]

  uart_dbg_txser #(
    .CLK_DIV (CLK_DIV)
  ) u_txser (
    .clk     (clk),
    .rst     (rst),
    .start_i (tx_start),
    .byte_i  (resp_q[7:0]),
    .tx_pin  (tx_pin),
    .done_o  (tx_done)
  );

  // ---------------- Frame FSM ----------------
  frame_state_t st;
  logic         is_wr;
  logic [1:0]   idx;      // bytes collected in ADDR/WDATA; bytes left minus one in RESP
  logic [15:0]  to_cnt;
  logic [31:0]  addr_q;
  logic [31:0]  wdata_q;

  assign waddr_o = addr_q;
  assign raddr_o = addr_q;
  assign data_o  = wdata_q;
  assign sel_o   = 4'hF;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_IDLE;
      busy_o   <= 1'b0;
      we_o     <= 1'b0;
      rd_o     <= 1'b0;
      tx_start <= 1'b0;
      is_wr    <= 1'b0;
      idx      <= '0;
      to_cnt   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      we_o     <= 1'b0;
      rd_o     <= 1'b0;
      tx_start <= 1'b0;
      case (st)
        S_IDLE: begin
          if (rx_vld && (rx_sh == CMD_WR || rx_sh == CMD_RD)) begin
            is_wr  <= (rx_sh == CMD_WR);
            idx    <= '0;
            to_cnt <= '0;
            busy_o <= 1'b1;
            st     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_vld) begin
            addr_q <= {rx_sh, addr_q[31:8]};
            to_cnt <= '0;
            if (idx == 2'd3) begin
              idx <= '0;
              if (is_wr) begin
                st <= S_WDATA;
              end else begin
                rd_o <= 1'b1;
                st   <= S_BUS_RD;
              end
            end else begin
              idx <= idx + 2'd1;
            end
          end else if (to_cnt == TO_LIM) begin
            busy_o <= 1'b0;
            st     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        S_WDATA: begin
          if (rx_vld) begin
            wdata_q <= {rx_sh, wdata_q[31:8]};
            to_cnt  <= '0;
            if (idx == 2'd3) begin
              idx  <= '0;
              we_o <= 1'b1;
              st   <= S_BUS_WR;
            end else begin
              idx <= idx + 2'd1;
            end
          end else if (to_cnt == TO_LIM) begin
            busy_o <= 1'b0;
            st     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        S_BUS_WR: begin
          resp_q   <= {24'h0, ACK_BYTE};
          idx      <= 2'd0;
          tx_start <= 1'b1;
          st       <= S_RESP;
        end
        S_BUS_RD: begin
          st <= S_RD_CAP;
        end
        S_RD_CAP: begin
          resp_q   <= data_i;
          idx      <= 2'd3;
          tx_start <= 1'b1;
          st       <= S_RESP;
        end
        S_RESP: begin
          if (tx_done) begin
            if (idx == 2'd0) begin
              busy_o <= 1'b0;
              st     <= S_IDLE;
            end else begin
              idx      <= idx - 2'd1;
              resp_q   <= {8'h00, resp_q[31:8]};
              tx_start <= 1'b1;
            end
          end
        end
        default: begin
          busy_o <= 1'b0;
          st     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbg_master.sv
module tb_uart_dbg_master;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_pin = 1'b1;
  logic        tx_pin;
  logic [31:0] waddr_o, data_o, raddr_o;
  logic [31:0] data_i = 32'h0;
  logic [3:0]  sel_o;
  logic        we_o, rd_o, busy_o;

  int          total = 0;
  int          bad = 0;
  logic        ignore_tx = 1'b0;
  logic [31:0] slave_val = 32'h0;

  logic [31:0] exp_waddr[$];
  logic [31:0] exp_wdata[$];
  logic [31:0] exp_raddr[$];
  logic [7:0]  exp_tx[$];

  always #5 clk = ~clk;

  uart_dbg_master #(
    .CLK_DIV (DIV),
    .TIMEOUT (400)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_pin  (rx_pin),
    .tx_pin  (tx_pin),
    .waddr_o (waddr_o),
    .data_o  (data_o),
    .sel_o   (sel_o),
    .we_o    (we_o),
    .raddr_o (raddr_o),
    .rd_o    (rd_o),
    .data_i  (data_i),
    .busy_o  (busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  // Slave: read data is valid only in the cycle after rd_o.
  always @(posedge clk) data_i <= rd_o ? slave_val : 32'h0;

  // Bus monitor
  always @(negedge clk) begin
    if (we_o) begin
      if (exp_waddr.size() == 0) fail_now("we_unexpected", waddr_o);
      else begin
        chk("waddr", waddr_o, exp_waddr.pop_front());
        chk("wdata", data_o, exp_wdata.pop_front());
        chk("sel", {28'h0, sel_o}, 32'hF);
      end
    end
    if (rd_o) begin
      if (exp_raddr.size() == 0) fail_now("rd_unexpected", raddr_o);
      else chk("raddr", raddr_o, exp_raddr.pop_front());
    end
  end

  // TX monitor: a UART receiver sampling mid-bit
  initial begin : tx_mon
    logic [7:0] b;
    logic       startb, stopb;
    forever begin
      @(negedge tx_pin);
      repeat (DIV / 2) @(negedge clk);
      startb = tx_pin;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = tx_pin;
      end
      repeat (DIV) @(negedge clk);
      stopb = tx_pin;
      if (!ignore_tx) begin
        if (exp_tx.size() == 0) fail_now("tx_unexpected", {24'h0, b});
        else begin
          chk("tx_byte", {24'h0, b}, {24'h0, exp_tx.pop_front()});
          chk("tx_startbit", {31'h0, startb}, 32'h0);
          chk("tx_stopbit", {31'h0, stopb}, 32'h1);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stopv = 1'b1);
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx_pin = stopv;
    repeat (DIV) @(negedge clk);
    rx_pin = 1'b1;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic wait_not_busy(input int budget, input string name);
    int n = 0;
    while (busy_o !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_o !== 1'b0) fail_now(name, {31'h0, busy_o});
  endtask

  task automatic wait_tx_low(input int budget, input string name);
    int n = 0;
    while (tx_pin !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx_pin !== 1'b0) fail_now(name, {31'h0, tx_pin});
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_pin", {31'h0, tx_pin}, 32'h1);
    chk("rst_we", {31'h0, we_o}, 32'h0);
    chk("rst_rd", {31'h0, rd_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_sel", {28'h0, sel_o}, 32'hF);
    chk("rst_waddr", waddr_o, 32'h0);
    chk("rst_wdata", data_o, 32'h0);
    chk("rst_raddr", raddr_o, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: write
    exp_waddr.push_back(32'h2000_0010);
    exp_wdata.push_back(32'hDEAD_BEEF);
    exp_tx.push_back(8'hAC);
    send_write(32'h2000_0010, 32'hDEAD_BEEF);
    chk("t1_busy", {31'h0, busy_o}, 32'h1);
    wait_not_busy(600, "t1_busy_stuck");
    chk("t1_tx_drained", exp_tx.size(), 0);
    chk("t1_wr_drained", exp_waddr.size(), 0);

    // 2: read
    slave_val = 32'h1234_5678;
    exp_raddr.push_back(32'h3000_0004);
    exp_tx.push_back(8'h78);
    exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    send_read(32'h3000_0004);
    chk("t2_busy", {31'h0, busy_o}, 32'h1);
    wait_not_busy(2000, "t2_busy_stuck");
    chk("t2_tx_drained", exp_tx.size(), 0);
    chk("t2_rd_drained", exp_raddr.size(), 0);
    chk("t2_tx_idle", {31'h0, tx_pin}, 32'h1);

    // 3: junk byte and start glitch, then a valid write
    send_byte(8'h00);
    repeat (20) @(negedge clk);
    chk("t3_junk_busy", {31'h0, busy_o}, 32'h0);
    rx_pin = 1'b0;
    repeat (3) @(negedge clk);
    rx_pin = 1'b1;
    repeat (40) @(negedge clk);
    chk("t3_glitch_busy", {31'h0, busy_o}, 32'h0);
    exp_waddr.push_back(32'h0000_0100);
    exp_wdata.push_back(32'hCAFE_F00D);
    exp_tx.push_back(8'hAC);
    send_write(32'h0000_0100, 32'hCAFE_F00D);
    wait_not_busy(600, "t3_busy_stuck");
    chk("t3_tx_drained", exp_tx.size(), 0);

    // 4: timeout mid-frame, then a read
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h00);
    chk("t4_busy_mid", {31'h0, busy_o}, 32'h1);
    repeat (500) @(negedge clk);
    chk("t4_timed_out", {31'h0, busy_o}, 32'h0);
    slave_val = 32'hA1B2_C3D4;
    exp_raddr.push_back(32'h4000_0008);
    exp_tx.push_back(8'hD4);
    exp_tx.push_back(8'hC3);
    exp_tx.push_back(8'hB2);
    exp_tx.push_back(8'hA1);
    send_read(32'h4000_0008);
    wait_not_busy(2000, "t4_busy_stuck");
    chk("t4_tx_drained", exp_tx.size(), 0);

    // 5: framing error on a command byte
    send_byte(8'hA5, 1'b0);
    repeat (40) @(negedge clk);
    chk("t5_busy", {31'h0, busy_o}, 32'h0);

    // 6: reset during the second bit of the ACK
    ignore_tx = 1'b1;
    exp_waddr.push_back(32'h5000_0000);
    exp_wdata.push_back(32'h1122_3344);
    send_write(32'h5000_0000, 32'h1122_3344);
    wait_tx_low(200, "t6_no_ack_start");
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_tx_pin", {31'h0, tx_pin}, 32'h1);
    chk("t6_busy", {31'h0, busy_o}, 32'h0);
    chk("t6_we", {31'h0, we_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (250) @(negedge clk);
    ignore_tx = 1'b0;
    exp_waddr.push_back(32'h6000_0004);
    exp_wdata.push_back(32'h55AA_55AA);
    exp_tx.push_back(8'hAC);
    send_write(32'h6000_0004, 32'h55AA_55AA);
    wait_not_busy(600, "t6_busy_stuck");

    repeat (100) @(negedge clk);
    chk("end_wr_drained", exp_waddr.size(), 0);
    chk("end_rd_drained", exp_raddr.size(), 0);
    chk("end_tx_drained", exp_tx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
